// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush-to-bubble and saturating stall/bubble counters.
// Define PIPE_STAGE_SKID_EN for a registered in_ready and a second (skid) payload entry.
module pipe_stage_reg #(
    parameter int unsigned            DATA_W    = 288,
    parameter logic [DATA_W-1:0]      NOP_VALUE = '0,
    parameter int unsigned            CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic              w_in_fire;
    logic              w_out_fire;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_in_ready;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;

    assign in_ready = r_in_ready;

    // in_ready is low exactly while the skid entry is occupied, so the skid
    // entry is only ever written when the main entry is full and stalled.
    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            r_valid      <= 1'b0;
            r_data       <= NOP_VALUE;
            r_skid_valid <= 1'b0;
            r_skid_data  <= NOP_VALUE;
            r_in_ready   <= 1'b1;
        end else if (w_in_fire) begin
            if (!r_valid || out_ready) begin
                r_valid <= 1'b1;
                r_data  <= in_data;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= in_data;
                r_in_ready   <= 1'b0;
            end
        end else if (w_out_fire) begin
            if (r_skid_valid) begin
                r_data       <= r_skid_data;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end
`else
    assign in_ready = ~r_valid | out_ready;

    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
        end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end
`endif

    // Counters survive Flush; only Reset clears them.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_valid && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (!r_valid && out_ready && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register. Successor to the fixed-width, enable-only stage register between pipeline stages.
- Carries an arbitrary-width payload (concatenated Instr/PC4/operand bundle) with valid/ready flow control, flush-to-bubble and per-stage stall/bubble counters.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB. Control decode stays outside the block.

Parameters:
- DATA_W, 288, payload width in bits (default = 9 x 32-bit fields).
- NOP_VALUE, 0, payload value loaded on reset/flush; Instr field 0 decodes as sll $0 (a bubble).
- CNT_W, 16, width of each performance counter.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Flush  input  1  discard stage contents this cycle; synchronous.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept a payload this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  stage holds a valid payload.
- out_ready  input  1  downstream accepts the payload this cycle.
- out_data  output  DATA_W  held payload.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  output  CNT_W  cycles with out_valid=0 and out_ready=1.

Behaviour:
- Reset (Reset=1 at rising edge): out_valid=0, out_data=NOP_VALUE, stall_cnt=0, bubble_cnt=0. Any skid entry is emptied. Reset overrides everything else.
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Base mode (SKID_EN undefined):
  - in_ready = ~out_valid | out_ready (combinational).
  - On an input transfer: out_data <= in_data, out_valid <= 1, next cycle. Latency is 1 cycle.
  - On an output transfer with no input transfer: out_valid <= 0. out_data holds its last value; it is don't-care while out_valid=0.
  - Otherwise out_valid and out_data hold. This includes stall: out_valid=1, out_ready=0.
  - Simultaneous output and input transfer: the new payload replaces the old one, out_valid stays 1, full throughput.
- Flush=1 (Reset=0):
  - Next cycle: out_valid=0, out_data=NOP_VALUE.
  - A concurrent input transfer is discarded, and in_ready must still follow its rule.
  - Flush beats load in all cases.
- Counters:
  - Updated every non-reset cycle from the current out_valid/out_ready.
  - Each saturates at 2^CNT_W-1 (no wrap).
  - Flush does not clear the counters.
- The payload is treated as opaque. The block performs no decode and no arithmetic on it.
- Undefined/X in_data while in_valid=0 must never reach out_data when out_valid=1.

Optional Feature:
- Macro PIPE_STAGE_SKID_EN.
- Defined: in_ready becomes a register, cutting the combinational ready path; a second DATA_W skid entry is added.
  - in_ready resets to 1.
  - If a payload is accepted while the main entry is full and out_ready=0, it goes to the skid entry and in_ready <= 0.
  - When the main entry drains, the skid entry moves to the main entry; in_ready <= 1 the same cycle.
  - Ordering is strictly FIFO; capacity is 2. Latency into an empty stage is still 1 cycle.
  - Flush empties both entries and sets in_ready <= 1.
- Undefined: base mode only. No skid storage; in_ready is combinational.

Test Plan:
- Reset then idle, DATA_W=32: after Reset pulse, out_valid=0, out_data=0. With out_ready=1 held for 5 cycles, bubble_cnt=5 and stall_cnt=0.
- Streaming: in_valid=1, out_ready=1, in_data=0x10,0x11,0x12 on consecutive cycles. Required: out_data=0x10,0x11,0x12 one cycle later each, out_valid=1 throughout, in_ready=1 throughout.
- Stall: load 0xA5A5A5A5, then out_ready=0 for 3 cycles with in_valid=1, in_data=0xDEAD. Required: out_data holds 0xA5A5A5A5, in_ready=0 (base mode), stall_cnt=3. The cycle after out_ready=1, out_data=0xDEAD.
- Flush vs load: out_valid=1, Flush=1 with in_valid=1, in_data=0x1234 in the same cycle. Required next cycle: out_valid=0, out_data=0. 0x1234 never appears on out_data.
- Saturation, CNT_W=4: hold a stall for 20 cycles. Required: stall_cnt stops at 15.
- PIPE_STAGE_SKID_EN: with out_ready=0, accept 0x1 then 0x2. Required: in_ready=0 after the second accept. Then set out_ready=1. Required: out_data=0x1, then 0x2 on consecutive cycles, and in_ready returns to 1.
